multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS main controller: a Moore FSM that sequences the shared datapath (single memory, single ALU, IR, PC, register file) through fetch, decode, execute, memory and write-back steps for R-type, LW, SW, BEQ and J. It sits beside the datapath, takes the instruction from the IR and drives every mux select and write enable. An optional memory wait-state handshake stretches memory steps.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Instruction  in  32  IR contents; only [31:26] used; valid from DECODE onward
- mem_ready  in  1  memory access complete (used only with MEM_READY_EN)
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- state  out  4  current FSM state
- done  out  1  high in the final state of each instruction
- illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010.
- States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_COMPLETE 7, BRANCH 8, JUMP 9; 10-15 unused, go to FETCH.
- Transitions: FETCH->DECODE; DECODE->MEM_ADDR (LW/SW), EXECUTE (R), BRANCH (BEQ), JUMP (J), FETCH (other, illegal=1 that cycle); MEM_ADDR->MEM_READ (LW) or MEM_WRITE (SW); MEM_READ->MEM_WB; EXECUTE->R_COMPLETE; MEM_WB, MEM_WRITE, R_COMPLETE, BRANCH, JUMP->FETCH.
- Outputs (unlisted = 0):
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01.
  - DECODE: ALUSrcB=11.
  - MEM_ADDR: ALUSrcA, ALUSrcB=10.
  - MEM_READ: MemRead, IorD.
  - MEM_WB: RegWrite, MemToReg.
  - MEM_WRITE: MemWrite, IorD, done.
  - EXECUTE: ALUSrcA, ALUOp=10.
  - R_COMPLETE: RegWrite, RegDst, done.
  - BRANCH: ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01, done.
  - JUMP: PCWrite, PCSource=10, done.
  - MEM_WB also asserts done.
- Opcode is sampled only in DECODE; changes in other states have no effect.

## Timing
- Reset: state<=FETCH next edge; while reset high all outputs forced 0 (no PCWrite/IRWrite), state reads 0. Reset mid-instruction abandons it; first FETCH follows the cycle after reset falls.
- Cycles per instruction (no wait states): LW 5, SW 4, R 4, BEQ 3, J 3, illegal 2.
- Outputs are combinational from state only (Moore), except the MEM_READY_EN gating below.
- illegal and done never assert in the same cycle.

## Configuration
- MEM_READY_EN defined: FETCH, MEM_READ and MEM_WRITE hold until mem_ready=1 and leave on that edge. MemRead/MemWrite/IorD held throughout. PCWrite and IRWrite in FETCH and done in MEM_WRITE are gated by mem_ready, giving one PC increment and one IR load per fetch.
- Undefined: mem_ready ignored; each of those states lasts exactly one cycle. The port remains present.

## Structure
- Shared package mips_ctrl_pkg: state encodings, opcode constants, ALUOp, ALUSrcB and PCSource codes.
- Sub-module multicycle_output_decode: combinational state (+mem_ready) -> control outputs; top holds state register and next-state logic.

## Test plan
- Reset held 3 cycles mid-LW (state=3) -> all outputs 0 during reset; state=0 and PCWrite=1 the cycle after release.
- Instruction=0x8C000000 (LW) -> states 0,1,2,3,4,0; MemToReg=RegWrite=done=1 only in state 4.
- Instruction=0xAC000000 (SW) then 0x00000000 (R) -> SW: 0,1,2,5 with MemWrite=1 in 5; R: 0,1,6,7 with RegDst=RegWrite=1 in 7.
- Instruction=0x10000000 (BEQ) -> 0,1,8,0 with PCWriteCond=1, ALUOp=01, PCSource=01 in 8. Instruction=0x08000000 (J) -> 0,1,9,0 with PCWrite=1, PCSource=10 in 9.
- Opcode 111111 -> illegal=1 for exactly the DECODE cycle; next state 0; done stays 0.
- MEM_READY_EN, LW, mem_ready low 2 cycles in FETCH and MEM_READ -> each state lasts 3 cycles. PCWrite/IRWrite high only in the third FETCH cycle. Total 9 cycles.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller:
// FSM state encodings, opcode constants, datapath select codes and the
// packed control word passed from the output decoder to the top.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEM_ADDR   = 4'd2,
    S_MEM_READ   = 4'd3,
    S_MEM_WB     = 4'd4,
    S_MEM_WRITE  = 4'd5,
    S_EXECUTE    = 4'd6,
    S_R_COMPLETE = 4'd7,
    S_BRANCH     = 4'd8,
    S_JUMP       = 4'd9
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control word; field order matches the top-level port list.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       done;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/multicycle_output_decode.sv
// Moore output decoder: maps the current FSM state to the datapath control
// word. ready_i qualifies the one-shot side effects of stretched memory
// steps (PC/IR update in FETCH, done in MEM_WRITE); it is tied high by the
// top when wait states are not built in.
module multicycle_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;

  // Per-state control values; anything not listed stays zero.
  always_comb begin
    c = '0;
    case (state_i)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = ready_i;
        c.pc_write  = ready_i;
        c.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.done      = ready_i;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_R_COMPLETE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.done          = 1'b1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
        c.done      = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, next-state logic and
// reset gating of the Moore outputs. Defining MEM_READY_EN makes FETCH,
// MEM_READ and MEM_WRITE wait for mem_ready; otherwise mem_ready is ignored.
// Handshake: a stretched memory step keeps its access strobes high every
// cycle and leaves on the rising edge where mem_ready=1; PCWrite/IRWrite
// and MEM_WRITE's done fire only in that completing cycle.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        RegDst,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        done,
  output logic        illegal
);

  state_t            state_q, state_d;
  logic              mem_is_lw_q, mem_is_lw_d;
  logic              illegal_raw;
  logic              ready;
  logic [5:0]        opcode;
  logic [CTRL_W-1:0] ctrl_w;
  ctrl_t             ctrl;
  logic              unused_bits;

  assign opcode      = Instruction[31:26];
  assign unused_bits = ^{Instruction[25:0], mem_ready};

`ifdef MEM_READY_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  // State register; the LW/SW choice is captured in DECODE so later IR
  // changes cannot redirect the memory step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      mem_is_lw_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_is_lw_q <= mem_is_lw_d;
    end
  end

  // Next-state logic; opcode is only looked at in DECODE.
  always_comb begin
    state_d     = state_q;
    mem_is_lw_d = mem_is_lw_q;
    illegal_raw = 1'b0;
    case (state_q)
      S_FETCH: if (ready) state_d = S_DECODE;
      S_DECODE: begin
        mem_is_lw_d = (opcode == OP_LW);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:   state_d = mem_is_lw_q ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:   if (ready) state_d = S_MEM_WB;
      S_MEM_WRITE:  if (ready) state_d = S_FETCH;
      S_EXECUTE:    state_d = S_R_COMPLETE;
      default:      state_d = S_FETCH;
    endcase
  end

  multicycle_output_decode u_decode (
    .state_i (state_q),
    .ready_i (ready),
    .ctrl_o  (ctrl_w)
  );

  // Reset forces every output low so no PC/IR update leaks out while held.
  always_comb begin
    ctrl = ctrl_w;
    if (reset) ctrl = '0;
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign done        = ctrl.done;
  assign illegal     = illegal_raw & ~reset;
  assign state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control. Each row gives the inputs for
// one clock cycle and the state/control values expected during that cycle.
// Wait-state rows are added when MEM_READY_EN is defined.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instruction = 32'h0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg;
  logic        IRWrite, ALUSrcA, RegWrite, RegDst, done, illegal;
  logic [1:0]  ALUOp, ALUSrcB, PCSource;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .state(state), .done(done), .illegal(illegal)
  );

  // clock
  always #5 clk = ~clk;

  // Expected control word bit positions:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemToReg,IRWrite,ALUSrcA,
  //  RegWrite,RegDst,ALUOp[1:0],ALUSrcB[1:0],PCSource[1:0],done,illegal}
  localparam logic [17:0] PCW    = 18'h20000;
  localparam logic [17:0] PCWC   = 18'h10000;
  localparam logic [17:0] IORD   = 18'h08000;
  localparam logic [17:0] MRD    = 18'h04000;
  localparam logic [17:0] MWR    = 18'h02000;
  localparam logic [17:0] M2R    = 18'h01000;
  localparam logic [17:0] IRW    = 18'h00800;
  localparam logic [17:0] SRCA   = 18'h00400;
  localparam logic [17:0] RGW    = 18'h00200;
  localparam logic [17:0] RDST   = 18'h00100;
  localparam logic [17:0] OP_FN  = 18'h00080;
  localparam logic [17:0] OP_SUB = 18'h00040;
  localparam logic [17:0] SB_IMM = 18'h00020;
  localparam logic [17:0] SB_4   = 18'h00010;
  localparam logic [17:0] SB_SH  = 18'h00030;
  localparam logic [17:0] PS_J   = 18'h00008;
  localparam logic [17:0] PS_OUT = 18'h00004;
  localparam logic [17:0] DN     = 18'h00002;
  localparam logic [17:0] ILL    = 18'h00001;

  localparam logic [17:0] E_ZERO  = 18'h0;
  localparam logic [17:0] E_FETCH = PCW | MRD | IRW | SB_4;
  localparam logic [17:0] E_DEC   = SB_SH;
  localparam logic [17:0] E_MADDR = SRCA | SB_IMM;
  localparam logic [17:0] E_MRD   = MRD | IORD;
  localparam logic [17:0] E_MWB   = RGW | M2R | DN;
  localparam logic [17:0] E_MWR   = MWR | IORD | DN;
  localparam logic [17:0] E_EXE   = SRCA | OP_FN;
  localparam logic [17:0] E_RC    = RGW | RDST | DN;
  localparam logic [17:0] E_BR    = SRCA | OP_SUB | PCWC | PS_OUT | DN;
  localparam logic [17:0] E_J     = PCW | PS_J | DN;

  localparam logic [31:0] I_LW  = 32'h8C000000;
  localparam logic [31:0] I_SW  = 32'hAC000000;
  localparam logic [31:0] I_R   = 32'h00000000;
  localparam logic [31:0] I_BEQ = 32'h10000000;
  localparam logic [31:0] I_J   = 32'h08000000;
  localparam logic [31:0] I_BAD = 32'hFC000000;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] ctrl;
  } vec_t;

  vec_t vecs[$];

  // driver: append one cycle of stimulus plus expectation
  task automatic add(input logic r, input logic [31:0] i, input logic d,
                     input logic [3:0] s, input logic [17:0] c);
    vec_t v;
    v.rst = r; v.instr = i; v.rdy = d; v.st = s; v.ctrl = c;
    vecs.push_back(v);
  endtask

  function automatic logic [17:0] actual_ctrl();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
            ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, done, illegal};
  endfunction

  initial begin
    // reset
    add(1, I_LW, 1, 4'd0, E_ZERO);
    add(1, I_LW, 1, 4'd0, E_ZERO);
    // LW: 0,1,2,3,4
    add(0, I_LW, 1, 4'd0, E_FETCH);
    add(0, I_LW, 1, 4'd1, E_DEC);
    add(0, I_LW, 1, 4'd2, E_MADDR);
    add(0, I_LW, 1, 4'd3, E_MRD);
    add(0, I_LW, 1, 4'd4, E_MWB);
    // SW: 0,1,2,5
    add(0, I_SW, 1, 4'd0, E_FETCH);
    add(0, I_SW, 1, 4'd1, E_DEC);
    add(0, I_SW, 1, 4'd2, E_MADDR);
    add(0, I_SW, 1, 4'd5, E_MWR);
    // R: 0,1,6,7
    add(0, I_R, 1, 4'd0, E_FETCH);
    add(0, I_R, 1, 4'd1, E_DEC);
    add(0, I_R, 1, 4'd6, E_EXE);
    add(0, I_R, 1, 4'd7, E_RC);
    // BEQ: 0,1,8
    add(0, I_BEQ, 1, 4'd0, E_FETCH);
    add(0, I_BEQ, 1, 4'd1, E_DEC);
    add(0, I_BEQ, 1, 4'd8, E_BR);
    // J: 0,1,9
    add(0, I_J, 1, 4'd0, E_FETCH);
    add(0, I_J, 1, 4'd1, E_DEC);
    add(0, I_J, 1, 4'd9, E_J);
    // illegal opcode: pulse only in DECODE, back to FETCH
    add(0, I_BAD, 1, 4'd0, E_FETCH);
    add(0, I_BAD, 1, 4'd1, E_DEC | ILL);
    // LW whose IR changes after DECODE must still finish as LW
    add(0, I_BAD, 1, 4'd0, E_FETCH);
    add(0, I_LW,  1, 4'd1, E_DEC);
    add(0, I_SW,  1, 4'd2, E_MADDR);
    add(0, I_BAD, 1, 4'd3, E_MRD);
    add(0, I_J,   1, 4'd4, E_MWB);
    // reset held 3 cycles mid-LW, then a fresh fetch
    add(0, I_LW, 1, 4'd0, E_FETCH);
    add(0, I_LW, 1, 4'd1, E_DEC);
    add(0, I_LW, 1, 4'd2, E_MADDR);
    add(0, I_LW, 1, 4'd3, E_MRD);
    add(1, I_LW, 1, 4'd0, E_ZERO);
    add(1, I_LW, 1, 4'd0, E_ZERO);
    add(1, I_LW, 1, 4'd0, E_ZERO);
    add(0, I_LW, 1, 4'd0, E_FETCH);
    add(0, I_LW, 1, 4'd1, E_DEC);
    add(0, I_LW, 1, 4'd2, E_MADDR);
    add(0, I_LW, 1, 4'd3, E_MRD);
    add(0, I_LW, 1, 4'd4, E_MWB);
`ifdef MEM_READY_EN
    // LW with two wait cycles in FETCH and MEM_READ: 9 cycles total
    add(0, I_LW, 0, 4'd0, MRD | SB_4);
    add(0, I_LW, 0, 4'd0, MRD | SB_4);
    add(0, I_LW, 1, 4'd0, E_FETCH);
    add(0, I_LW, 0, 4'd1, E_DEC);
    add(0, I_LW, 0, 4'd2, E_MADDR);
    add(0, I_LW, 0, 4'd3, E_MRD);
    add(0, I_LW, 0, 4'd3, E_MRD);
    add(0, I_LW, 1, 4'd3, E_MRD);
    add(0, I_LW, 0, 4'd4, E_MWB);
    // SW stalled in MEM_WRITE: done only in the completing cycle
    add(0, I_SW, 1, 4'd0, E_FETCH);
    add(0, I_SW, 1, 4'd1, E_DEC);
    add(0, I_SW, 1, 4'd2, E_MADDR);
    add(0, I_SW, 0, 4'd5, MWR | IORD);
    add(0, I_SW, 1, 4'd5, E_MWR);
    add(0, I_SW, 1, 4'd0, E_FETCH);
`else
    // mem_ready low is ignored: no stretching
    add(0, I_LW, 0, 4'd0, E_FETCH);
    add(0, I_LW, 0, 4'd1, E_DEC);
    add(0, I_LW, 0, 4'd2, E_MADDR);
    add(0, I_LW, 0, 4'd3, E_MRD);
    add(0, I_LW, 0, 4'd4, E_MWB);
    add(0, I_SW, 0, 4'd0, E_FETCH);
    add(0, I_SW, 0, 4'd1, E_DEC);
    add(0, I_SW, 0, 4'd2, E_MADDR);
    add(0, I_SW, 0, 4'd5, E_MWR);
    add(0, I_SW, 0, 4'd0, E_FETCH);
`endif

    // apply and compare, one row per cycle, sampled mid low phase
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      reset       = vecs[n].rst;
      Instruction = vecs[n].instr;
      mem_ready   = vecs[n].rdy;
      #2;
      checks++;
      if (state !== vecs[n].st) begin
        errors++;
        $display("FAIL state row %0d: got %0d expected %0d", n, state, vecs[n].st);
      end
      checks++;
      if (actual_ctrl() !== vecs[n].ctrl) begin
        errors++;
        $display("FAIL ctrl row %0d (state %0d): got %05h expected %05h",
                 n, state, actual_ctrl(), vecs[n].ctrl);
      end
      checks++;
      if ((done & illegal) !== 1'b0) begin
        errors++;
        $display("FAIL done_illegal row %0d: done=%b illegal=%b expected not both",
                 n, done, illegal);
      end
    end

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
